buffer2_sram_writer: RTL



---
 rtl/edge_pkg.sv | 21 ++
 rtl/writer_addr_counter.sv | 48 ++++
 rtl/buffer2_sram_writer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/edge_pkg.sv
`default_nettype none
// ============================================================================
// Module      : edge_pkg
// Description : Shared types and constants for the edge-detection writer path.
// Revision    : 1.0 - initial release
// ============================================================================
package edge_pkg;

    localparam int BYTES_PER_PIXEL = 4;
    localparam int PIXEL_WORD_W    = 32;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_DATA = 3'd1,
        ST_WRITE     = 3'd2,
        ST_COMPLETE  = 3'd3,
        ST_DRAIN     = 3'd4
    } writer_state_t;

endpackage
`default_nettype wire

// File: rtl/writer_addr_counter.sv
`default_nettype none
// ============================================================================
// Module      : writer_addr_counter
// Description : Loadable byte-address register and pixel counter for the
//               SRAM writer; flags when the next accepted write is the last.
// Revision    : 1.0 - initial release
// ============================================================================
module writer_addr_counter
    import edge_pkg::*;
#(
    parameter int NUM_PIXELS = 307200,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_advance,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_last
);

    localparam int                CNT_W  = $clog2(NUM_PIXELS + 1);
    localparam logic [ADDR_W-1:0] c_step = ADDR_W'(BYTES_PER_PIXEL);
    localparam logic [CNT_W-1:0]  c_last = CNT_W'(NUM_PIXELS - 1);

    logic [ADDR_W-1:0] r_address;
    logic [CNT_W-1:0]  r_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_address <= '0;
            r_count   <= '0;
        end else if (i_load) begin
            r_address <= i_base_addr;
            r_count   <= '0;
        end else if (i_advance) begin
            // Address wraps modulo 2^ADDR_W by construction
            r_address <= r_address + c_step;
            r_count   <= r_count + 1'b1;
        end
    end

    assign o_address = r_address;
    assign o_last    = (r_count == c_last);

endmodule
`default_nettype wire

// File: rtl/buffer2_sram_writer.sv
`default_nettype none
// ============================================================================
// Module      : buffer2_sram_writer
// Description : Drains output buffer 2 into SRAM through an Avalon-MM write
//               master, handshaking each consumed word back to the buffer.
// Revision    : 1.0 - initial release
// ============================================================================
module buffer2_sram_writer
    import edge_pkg::*;
#(
    parameter int NUM_PIXELS = 307200,
    parameter int ADDR_W     = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_start,
    input  logic [ADDR_W-1:0]       i_base_addr,
    input  logic [PIXEL_WORD_W-1:0] i_buffer2_data,
    input  logic                    i_start_next_write,
    input  logic                    i_empty,
    input  logic                    i_waitrequest,
    output logic [ADDR_W-1:0]       o_address,
    output logic                    o_write,
    output logic [PIXEL_WORD_W-1:0] o_writedata,
    output logic [3:0]              o_byteenable,
    output logic                    o_write_complete,
    output logic                    o_frame_done,
    output logic                    o_busy
);

    writer_state_t           r_state;
    logic [PIXEL_WORD_W-1:0] r_data;
    logic                    r_write;
    logic [3:0]              r_byteenable;
    logic                    r_write_complete;
    logic                    r_frame_done;
    logic                    r_busy;

    logic w_load;
    logic w_advance;
    logic w_last;

    assign w_load    = (r_state == ST_IDLE) && i_start;
    assign w_advance = (r_state == ST_WRITE) && !i_waitrequest;

    writer_addr_counter #(
        .NUM_PIXELS (NUM_PIXELS),
        .ADDR_W     (ADDR_W)
    ) u_addr_counter (
        .clk         (clk),
        .rst         (rst),
        .i_load      (w_load),
        .i_base_addr (i_base_addr),
        .i_advance   (w_advance),
        .o_address   (o_address),
        .o_last      (w_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_IDLE;
            r_data           <= '0;
            r_write          <= 1'b0;
            r_byteenable     <= 4'b0000;
            r_write_complete <= 1'b0;
            r_frame_done     <= 1'b0;
            r_busy           <= 1'b0;
        end else begin
            r_write_complete <= 1'b0;
            r_frame_done     <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_state <= ST_WAIT_DATA;
                        r_busy  <= 1'b1;
                    end
                end
                ST_WAIT_DATA: begin
                    if (i_start_next_write && !i_empty) begin
                        r_data       <= i_buffer2_data;
                        r_write      <= 1'b1;
                        r_byteenable <= 4'b1111;
                        r_state      <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!i_waitrequest) begin
                        r_write          <= 1'b0;
                        r_byteenable     <= 4'b0000;
                        r_write_complete <= 1'b1;
                        // Frame done must line up with the final completion pulse
                        r_frame_done     <= w_last;
                        r_state          <= ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    if (r_frame_done) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    // Buffer keeps its valid flag up while advancing; wait it out
                    if (!i_start_next_write) begin
                        r_state <= ST_WAIT_DATA;
                    end
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_write      <= 1'b0;
                    r_byteenable <= 4'b0000;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign o_write          = r_write;
    assign o_writedata      = r_data;
    assign o_byteenable     = r_byteenable;
    assign o_write_complete = r_write_complete;
    assign o_frame_done     = r_frame_done;
    assign o_busy           = r_busy;

endmodule
`default_nettype wire
